// File: rtl/aurora_tx_pkg.sv
// Shared types and sizing helpers for the Aurora TX mux serializer.
package aurora_tx_pkg;

  localparam int HDR_CH_W  = 4;
  localparam int HDR_SEQ_W = 4;

  typedef enum logic [2:0] {IDLE, ARB, WAIT, LOAD, SEND} tx_state_e;

  function automatic int calc_beats(input int pkt_bits, input int tdata_bits);
    return (pkt_bits + tdata_bits - 1) / tdata_bits;
  endfunction

  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Byte enables for the final beat; the first packet byte sits in the MSB lane.
  function automatic logic [127:0] last_keep(input int pkt_bits, input int tdata_bits);
    logic [127:0] m;
    int nb, rb;
    nb = tdata_bits / 8;
    rb = (pkt_bits % tdata_bits) / 8;
    m  = '0;
    for (int i = 0; i < nb; i++)
      if (rb == 0 || i >= nb - rb) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/aurora_tx_mux_serializer_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              found_o
);

  int idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NUM_CH;
      if (req_i[idx]) begin
        grant_o = CH_W'(idx);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aurora_tx_mux_serializer.sv
// Round-robin multi-FIFO packet mux with header insertion, serialized onto Aurora AXI4-Stream TX.
// Define TX_SEQ_EN to carry a per-channel 4-bit sequence number in the header low nibble.
module aurora_tx_mux_serializer
  import aurora_tx_pkg::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int PACKET_SIZE   = 128,
  parameter  int TX_TDATA_SIZE = 32,
  localparam int CH_W          = calc_ch_w(NUM_CH)
) (
  input  logic                               user_clk,
  input  logic                               RST,
  input  logic                               start,
  input  logic [NUM_CH*(PACKET_SIZE-8)-1:0]  d_out,
  input  logic [NUM_CH-1:0]                  empty,
  output logic [NUM_CH-1:0]                  rd_en,
  input  logic                               s_axi_tx_tready,
  output logic                               s_axi_tx_tvalid,
  output logic                               s_axi_tx_tlast,
  output logic [TX_TDATA_SIZE-1:0]           s_axi_tx_tdata,
  output logic [TX_TDATA_SIZE/8-1:0]         s_axi_tx_tkeep,
  output logic [CH_W-1:0]                    cur_ch
);

  localparam int INPUT_SIZE = PACKET_SIZE - 8;
  localparam int BEATS      = calc_beats(PACKET_SIZE, TX_TDATA_SIZE);
  localparam int CNT_W      = calc_cnt_w(BEATS);
  localparam int SR_W       = BEATS * TX_TDATA_SIZE;
  localparam int KW         = TX_TDATA_SIZE / 8;
  localparam logic [KW-1:0] KEEP_LAST = KW'(last_keep(PACKET_SIZE, TX_TDATA_SIZE));

  tx_state_e            state_q, state_d;
  logic                 start_q;
  logic [NUM_CH-1:0]    empty_q;
  logic [CH_W-1:0]      ptr_q, ptr_d, gnt_q, gnt_d, arb_gnt, next_ptr;
  logic                 arb_found;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hs, last_beat;
  logic [HDR_SEQ_W-1:0] hdr_seq;
  logic [7:0]           hdr;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req_i   (~empty_q),
    .ptr_i   (ptr_q),
    .grant_o (arb_gnt),
    .found_o (arb_found)
  );

  assign hs        = s_axi_tx_tvalid && s_axi_tx_tready;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign next_ptr  = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + CH_W'(1);
  assign hdr       = {HDR_CH_W'(gnt_q), hdr_seq};

`ifdef TX_SEQ_EN
  logic [NUM_CH-1:0][HDR_SEQ_W-1:0] seq_q;

  always_ff @(posedge user_clk) begin
    if (RST)                   seq_q        <= '0;
    else if (hs && last_beat)  seq_q[gnt_q] <= seq_q[gnt_q] + HDR_SEQ_W'(1);
  end

  assign hdr_seq = seq_q[gnt_q];
`else
  assign hdr_seq = '0;
`endif

  always_ff @(posedge user_clk) begin
    if (RST) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      empty_q <= '1;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      empty_q <= empty;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    rd_en   = '0;
    case (state_q)
      IDLE: if (start_q) state_d = ARB;
      ARB: begin
        if (!start_q) begin
          state_d = IDLE;
        end else if (arb_found) begin
          gnt_d   = arb_gnt;
          rd_en   = NUM_CH'(1) << arb_gnt;
          state_d = WAIT;
        end
      end
      WAIT: state_d = LOAD;
      LOAD: begin
        // Left-justify header+payload so beat 0 is always the top slice.
        sr_d    = SR_W'({hdr, d_out[int'(gnt_q)*INPUT_SIZE +: INPUT_SIZE]}) << (SR_W - PACKET_SIZE);
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (hs) begin
          sr_d  = sr_q << TX_TDATA_SIZE;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            ptr_d   = next_ptr;
            state_d = ARB;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_axi_tx_tvalid = (state_q == SEND);
  assign s_axi_tx_tlast  = s_axi_tx_tvalid && last_beat;
  assign s_axi_tx_tdata  = sr_q[SR_W-1 -: TX_TDATA_SIZE];
  assign s_axi_tx_tkeep  = !s_axi_tx_tvalid ? '0 : (s_axi_tx_tlast ? KEEP_LAST : '1);
  assign cur_ch          = gnt_q;

endmodule

// File: tb/tb_aurora_tx_mux_serializer.sv
// Scoreboard bench: main instance (4 ch, 128b packets, 32b beats) plus an 80b-packet instance for partial tkeep.
module tb_aurora_tx_mux_serializer;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } beat_t;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, tready;
  logic [479:0] d_out;
  logic [3:0]   empty, rd_en;
  logic         tvalid, tlast;
  logic [31:0]  tdata;
  logic [3:0]   tkeep;
  logic [1:0]   cur_ch;

  logic         start2, tready2;
  logic [143:0] d_out2;
  logic [1:0]   empty2, rd_en2;
  logic         tvalid2, tlast2;
  logic [31:0]  tdata2;
  logic [3:0]   tkeep2;
  logic [0:0]   cur_ch2;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;

  logic [119:0] fq [4][$];
  beat_t        sb[$];
  int           exp_ch[$];
  int           mseq[4];

  beat_t        e;
  int           exp_c;
  logic         prev_stall = 1'b0;
  logic [31:0]  p_data;
  logic         p_last;
  logic [3:0]   p_keep;

  logic         bp_en = 1'b0;
  int           bp_i = 0;
  logic [3:0]   bp_pat = 4'b1001;

  aurora_tx_mux_serializer #(.NUM_CH(4), .PACKET_SIZE(128), .TX_TDATA_SIZE(32)) dut (
    .user_clk(clk), .RST(rst), .start(start), .d_out(d_out), .empty(empty), .rd_en(rd_en),
    .s_axi_tx_tready(tready), .s_axi_tx_tvalid(tvalid), .s_axi_tx_tlast(tlast),
    .s_axi_tx_tdata(tdata), .s_axi_tx_tkeep(tkeep), .cur_ch(cur_ch)
  );

  aurora_tx_mux_serializer #(.NUM_CH(2), .PACKET_SIZE(80), .TX_TDATA_SIZE(32)) dut2 (
    .user_clk(clk), .RST(rst), .start(start2), .d_out(d_out2), .empty(empty2), .rd_en(rd_en2),
    .s_axi_tx_tready(tready2), .s_axi_tx_tvalid(tvalid2), .s_axi_tx_tlast(tlast2),
    .s_axi_tx_tdata(tdata2), .s_axi_tx_tkeep(tkeep2), .cur_ch(cur_ch2)
  );

  // FIFO model: word appears on d_out after the read strobe is seen.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rd_en[k] && fq[k].size() > 0) d_out[k*120 +: 120] = fq[k].pop_front();
      empty[k] = (fq[k].size() == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      tready = bp_pat[3 - (bp_i % 4)];
      bp_i++;
    end
  end

  // Monitor: grants, beats and backpressure stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en != 4'b0) begin
        checks++;
        if (exp_ch.size() == 0) begin
          failures++;
          $display("FAIL rd_en_unexpected: got %b, expected no read", rd_en);
        end else begin
          exp_c = exp_ch.pop_front();
          if (rd_en !== (4'b1 << exp_c)) begin
            failures++;
            $display("FAIL rd_en_grant: got %b, expected channel %0d", rd_en, exp_c);
          end
        end
      end
      if (prev_stall) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== p_data || tlast !== p_last || tkeep !== p_keep) begin
          failures++;
          $display("FAIL hold_stable: got v=%b d=%h l=%b k=%h, expected v=1 d=%h l=%b k=%h",
                   tvalid, tdata, tlast, tkeep, p_data, p_last, p_keep);
        end
      end
      if (tvalid && tready) begin
        hs_cnt++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected: got d=%h l=%b, expected no beat", tdata, tlast);
        end else begin
          e = sb.pop_front();
          if (tdata !== e.data || tlast !== e.last || tkeep !== e.keep) begin
            failures++;
            $display("FAIL beat: got d=%h l=%b k=%h, expected d=%h l=%b k=%h",
                     tdata, tlast, tkeep, e.data, e.last, e.keep);
          end
        end
      end
      prev_stall = tvalid && !tready;
      p_data = tdata; p_last = tlast; p_keep = tkeep;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic expect_pkt(input int ch, input logic [119:0] w);
    logic [127:0] p;
    logic [3:0]   s;
`ifdef TX_SEQ_EN
    s = 4'(mseq[ch]);
    mseq[ch] = (mseq[ch] + 1) % 16;
`else
    s = 4'h0;
`endif
    p = {4'(ch), s, w};
    exp_ch.push_back(ch);
    for (int b = 0; b < 4; b++) sb.push_back('{p[127-32*b -: 32], (b == 3), 4'hF});
  endtask

  task automatic clear_model();
    sb.delete();
    exp_ch.delete();
    for (int k = 0; k < 4; k++) begin
      mseq[k] = 0;
      fq[k].delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || exp_ch.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || exp_ch.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d beats and %0d grants outstanding, expected 0", name, sb.size(), exp_ch.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({tvalid, tlast, tkeep, rd_en, cur_ch} !== 12'h0) begin
      failures++;
      $display("FAIL reset_ctrl: got v=%b l=%b k=%h rd=%b ch=%0d, expected all 0", tvalid, tlast, tkeep, rd_en, cur_ch);
    end
    checks++;
    if (tdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_tdata: got %h, expected 0", tdata);
    end
    checks++;
    if ({tvalid2, rd_en2, tkeep2} !== 7'h0) begin
      failures++;
      $display("FAIL reset_dut2: got v=%b rd=%b k=%h, expected 0", tvalid2, rd_en2, tkeep2);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    fq[2].push_back({88'hAABBCCDD_11223344_556677, 32'h0});
    exp_ch.push_back(2);
    sb.push_back('{32'h20AABBCC, 1'b0, 4'hF});
    sb.push_back('{32'hDD112233, 1'b0, 4'hF});
    sb.push_back('{32'h44556677, 1'b0, 4'hF});
    sb.push_back('{32'h00000000, 1'b1, 4'hF});
`ifdef TX_SEQ_EN
    mseq[2] = 1;
`endif
    @(negedge clk); @(posedge clk); #1;
    start = 1'b1;
    wait_drain("single", 100);
    start = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [119:0] w [2][4];
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        w[r][k] = 120'({$urandom, $urandom, $urandom, $urandom});
        fq[k].push_back(w[r][k]);
      end
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) expect_pkt(k, w[r][k]);
    @(negedge clk); @(posedge clk); #1;
    start = 1'b1;
    wait_drain("round_robin", 300);
    start = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [119:0] w;
    int base;
    w = 120'({$urandom, $urandom, $urandom, $urandom});
    fq[0].push_back(w);
    expect_pkt(0, w);
    base = hs_cnt;
    bp_i = 0;
    bp_en = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    start = 1'b1;
    wait_drain("backpressure", 200);
    bp_en = 1'b0;
    @(posedge clk); #1;
    tready = 1'b1;
    start = 1'b0;
    checks++;
    if (hs_cnt - base !== 4) begin
      failures++;
      $display("FAIL bp_handshakes: got %0d, expected 4", hs_cnt - base);
    end
  endtask

  task automatic test_start_drop();
    int n = 0;
    int seen = 0;
    logic [119:0] w;
    for (int i = 0; i < 3; i++) begin
      w = 120'({$urandom, $urandom, $urandom, $urandom});
      fq[1].push_back(w);
      if (i == 0) expect_pkt(1, w);
    end
    @(negedge clk); @(posedge clk); #1;
    start = 1'b1;
    while (!tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("start_drop", 50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tvalid || rd_en != 4'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL start_drop_idle: got %0d active cycles, expected 0", seen);
    end
    fq[1].delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int base;
    logic [119:0] w;
    w = 120'({$urandom, $urandom, $urandom, $urandom});
    fq[0].push_back(w);
    expect_pkt(0, w);
    base = hs_cnt;
    @(negedge clk); @(posedge clk); #1;
    start = 1'b1;
    while (hs_cnt == base && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || rd_en !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b l=%b rd=%b, expected 0", tvalid, tlast, rd_en);
    end
    w = 120'({$urandom, $urandom, $urandom, $urandom});
    fq[0].push_back(w);
    expect_pkt(0, w);
    wait_drain("reset_mid", 100);
    start = 1'b0;
  endtask

  task automatic test_wrap();
    logic [119:0] w;
    for (int i = 0; i < 17; i++) begin
      w = 120'({$urandom, $urandom, $urandom, $urandom});
      fq[1].push_back(w);
      expect_pkt(1, w);
    end
    @(negedge clk); @(posedge clk); #1;
    start = 1'b1;
    wait_drain("wrap", 400);
    start = 1'b0;
  endtask

  task automatic test_partial();
    beat_t ex [3];
    int n = 0;
    int got = 0;
    ex[0] = '{32'h00010203, 1'b0, 4'hF};
    ex[1] = '{32'h04050607, 1'b0, 4'hF};
    ex[2] = '{32'h08090000, 1'b1, 4'b1100};
    @(posedge clk); #1;
    d_out2[71:0] = 72'h01_0203_0405_0607_0809;
    empty2 = 2'b10;
    start2 = 1'b1;
    while (rd_en2 == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rd_en2 !== 2'b01) begin
      failures++;
      $display("FAIL partial_grant: got %b, expected 01", rd_en2);
    end
    @(posedge clk); #1;
    empty2 = 2'b11;
    n = 0;
    while (got < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (tvalid2 && tready2) begin
        checks++;
        if (tdata2 !== ex[got].data || tlast2 !== ex[got].last || tkeep2 !== ex[got].keep) begin
          failures++;
          $display("FAIL partial_beat%0d: got d=%h l=%b k=%b, expected d=%h l=%b k=%b",
                   got, tdata2, tlast2, tkeep2, ex[got].data, ex[got].last, ex[got].keep);
        end
        got++;
      end
    end
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL partial_count: got %0d beats, expected 3", got);
    end
    start2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tready = 1'b1;
    d_out = '0; empty = '1;
    start2 = 1'b0; tready2 = 1'b1; d_out2 = '0; empty2 = '1;
    for (int k = 0; k < 4; k++) mseq[k] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_start_drop();
    test_reset_mid();
    test_wrap();
    test_partial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aurora_tx_mux_serializer.md
Name: aurora_tx_mux_serializer

Overview:
- Successor to the single-FIFO Aurora TX serializer.
- Round-robin arbitrates NUM_CH packet FIFOs and prepends a header byte (channel ID plus per-channel sequence) to each payload.
- Splits each packet into TX_TDATA_SIZE beats on the Aurora AXI4-Stream TX port, with full per-beat tready backpressure and tkeep on a partial last beat.
- Sits between the per-channel packet FIFOs and the Aurora core s_axi_tx_* interface.

Parameters:
- NUM_CH, 4: number of source FIFOs, 1..16.
- PACKET_SIZE, 128: packet bits including the 8-bit header.
- TX_TDATA_SIZE, 32: Aurora tdata width, multiple of 8.
- Derived localparams:
  - INPUT_SIZE = PACKET_SIZE-8.
  - BEATS = ceil(PACKET_SIZE/TX_TDATA_SIZE), must be >=2.
  - CNT_W = $clog2(BEATS).
  - CH_W = max(1,$clog2(NUM_CH)).
  - Constraint: PACKET_SIZE mod 8 == 0.

Ports:
- user_clk  in  1  clock.
- RST  in  1  synchronous active-high reset.
- start  in  1  level enable; low = finish current packet, then idle.
- d_out  in  NUM_CH*INPUT_SIZE  FIFO read data; channel k occupies bits [k*INPUT_SIZE +: INPUT_SIZE].
- empty  in  NUM_CH  FIFO empty flags.
- rd_en  out  NUM_CH  one-hot FIFO read strobe.
- s_axi_tx_tready  in  1  Aurora ready.
- s_axi_tx_tvalid  out  1  beat valid.
- s_axi_tx_tlast  out  1  last beat of packet.
- s_axi_tx_tdata  out  TX_TDATA_SIZE  beat data; MSB-first packet order.
- s_axi_tx_tkeep  out  TX_TDATA_SIZE/8  byte enables; MSB byte = first byte.
- cur_ch  out  CH_W  channel of the packet in flight (debug).

Behaviour:
- Reset: all outputs 0. FSM = IDLE. RR pointer = 0. All sequence counters = 0. Shift register = 0.
- Inputs start and empty are registered once before use. Aurora outputs are driven directly from the shift register and beat counter, with no extra output stage.
- FSM states:
  - IDLE: wait for start_reg=1, then go to ARB.
  - ARB:
    - If start_reg=0, go to IDLE.
    - Search empty_reg for a non-empty channel, starting at ptr and wrapping.
    - If none is found, stay in ARB.
    - Otherwise latch grant g, pulse rd_en[g] for exactly 1 cycle, and go to WAIT.
  - WAIT: one cycle; FIFO data becomes valid on d_out slice g. Go to LOAD.
  - LOAD:
    - Shift register <= {hdr, d_out slice g}, left-justified, zero-padded to BEATS*TX_TDATA_SIZE.
    - Beat counter = 0. Go to SEND.
  - SEND:
    - tvalid=1. tdata = top TX_TDATA_SIZE bits of the shift register.
    - On tvalid&&tready: shift left by TX_TDATA_SIZE and increment the beat counter.
    - tlast=1 when beat counter == BEATS-1.
    - On the tlast handshake: seq[g]++ (wraps 15->0), ptr <= g+1 mod NUM_CH, go to ARB.
- Header byte:
  - Upper 4 bits = g (zero-extended).
  - Lower 4 bits = seq[g] (TX_SEQ_EN dependent, see Optional Feature).
- Backpressure:
  - tdata, tlast and tkeep hold stable while tvalid=1 and tready=0.
  - tvalid never deasserts mid-packet.
- tkeep:
  - All ones except on the last beat when PACKET_SIZE mod TX_TDATA_SIZE != 0.
  - In that case the upper (PACKET_SIZE mod TX_TDATA_SIZE)/8 bytes are 1 and the rest 0.
- start deasserted mid-packet: the packet completes normally, then the FSM goes ARB -> IDLE.
- empty rising after grant: ignored. Only one word is read per grant, and the FIFO guarantees the word.
- Minimum gap between packets: 3 idle cycles (ARB, WAIT, LOAD).
- NUM_CH=1: the arbiter degenerates to channel 0. Header upper nibble = 0.
- RST mid-packet: the packet is abandoned and tvalid drops the next cycle. No tlast is issued for the partial packet.

Optional Feature:
- Macro TX_SEQ_EN.
- Defined: header lower nibble = seq[g]. Per-channel 4-bit sequence counters are instantiated.
- Undefined: lower nibble = 4'b0000. No sequence counters are instantiated.

Decomposition:
- Package aurora_tx_pkg holds:
  - Header field widths (CH field 4, SEQ field 4).
  - The BEATS/CNT_W/tkeep-mask functions.
  - The FSM state enum {IDLE, ARB, WAIT, LOAD, SEND}.
- One sub-module: rr_arbiter (NUM_CH request vector, pointer in, grant index plus found flag out; combinational search, with the pointer register kept in the parent).

Test Plan:
- Single channel, defaults: ch2 has 1 word 0xAABBCCDD_11223344_556677, tready=1 -> 4 beats 0x20AABBCC, 0xDD112233, 0x44556677, 0x00000000; tlast on beat 4; tkeep=0xF on every beat.
- Round robin: all 4 channels hold 2 words each, start=1 -> grant order 0,1,2,3,0,1,2,3; second packet of each channel has seq nibble 1.
- Backpressure: tready toggles 1,0,0,1 every cycle -> each beat is held stable while tready=0; exactly 4 handshakes; tlast only on the 4th.
- Partial beat: PACKET_SIZE=80, TX_TDATA_SIZE=32 -> 3 beats; last tkeep=4'b1100.
- Start drop: deassert start during beat 2 -> packet finishes with tlast; no further rd_en; FSM returns to IDLE.
- Reset mid-packet: RST at beat 2 -> next cycle tvalid=0, rd_en=0, seq counters reset; the following packet from ch0 carries header 0x00.
- Wrap: 17 packets from ch1 with TX_SEQ_EN defined -> the 17th header is 0x10 (seq wrapped); with the macro undefined, all headers are 0x10.
